// File: rtl/decoder_scan_sequencer.sv
// Select-code sequencer for a 3-to-8 decoder: programmable order, dwell, sweep mode and slot mask.
// Slot skipping is compiled in only when DECODER_SCAN_SKIP_MASK_EN is defined.
module decoder_scan_sequencer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic               mode_i,
    input  logic               start_i,
    input  logic               dir_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic [7:0]         mask_i,
    output logic               s2_o,
    output logic               s1_o,
    output logic               s0_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               wrap_o,
    output logic               err_o
);

    localparam logic StIdle = 1'b0;
    localparam logic StScan = 1'b1;

    logic               state_q, state_d;
    logic [2:0]         slot_q, slot_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
    logic [7:0]         mask_eff;
    logic [2:0]         nxt;
    logic               wrapped;

`ifdef DECODER_SCAN_SKIP_MASK_EN
    assign mask_eff = mask_i;
`else
    logic unused_mask;
    assign unused_mask = ^mask_i;
    assign mask_eff    = 8'hFF;
`endif

    // Lowest set bit for ascending order, highest for descending (last write wins).
    function automatic logic [2:0] first_slot(input logic [7:0] m, input logic d);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!d && m[7-i]) r = 3'(7 - i);
            if (d && m[i])    r = 3'(i);
        end
        return r;
    endfunction

    // Nearest enabled slot after c in direction d, modulo 8; c itself if it is the only one.
    function automatic logic [2:0] next_slot(input logic [7:0] m, input logic [2:0] c,
                                             input logic d);
        logic [2:0] r;
        logic [2:0] idx;
        r = c;
        for (int k = 7; k >= 1; k--) begin
            idx = d ? c - 3'(k) : c + 3'(k);
            if (m[idx]) r = idx;
        end
        return r;
    endfunction

    assign nxt     = next_slot(mask_eff, slot_q, dir_i);
    assign wrapped = dir_i ? (nxt >= slot_q) : (nxt <= slot_q);

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (!en_i) begin
            state_d = StIdle;
        end else if (state_q == StIdle) begin
            if (!mode_i || start_i) begin
                if (mask_eff == '0) begin
                    err_d = 1'b1;
                end else begin
                    state_d = StScan;
                    slot_d  = first_slot(mask_eff, dir_i);
                    cnt_d   = dwell_i;
                end
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (mask_eff == '0) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end else begin
            cnt_d = dwell_i;
            if (wrapped) begin
                wrap_d = 1'b1;
                // A single sweep ends holding the last slot's select code.
                if (mode_i) state_d = StIdle;
                else        slot_d  = nxt;
            end else begin
                slot_d = nxt;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            slot_q  <= 3'd0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign {s2_o, s1_o, s0_o} = slot_q;
    assign valid_o            = (state_q == StScan);
    assign busy_o             = (state_q == StScan);
    assign wrap_o             = wrap_q;
    assign err_o              = err_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer: per-cycle expectations queued, popped after each edge.
module tb_decoder_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, en, mode, start, dir;
    logic [7:0] dwell, mask;
    logic       s2, s1, s0, valid, busy, wrap, err;

    int n_vec  = 0;
    int n_fail = 0;

    logic [6:0] exp_q[$];
    string      tag_q[$];

    decoder_scan_sequencer #(.DWELL_W(8)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en),
        .mode_i  (mode),
        .start_i (start),
        .dir_i   (dir),
        .dwell_i (dwell),
        .mask_i  (mask),
        .s2_o    (s2),
        .s1_o    (s1),
        .s0_o    (s0),
        .valid_o (valid),
        .busy_o  (busy),
        .wrap_o  (wrap),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    // Observed word: {sel[2:0], valid, busy, wrap, err}
    task automatic chk(input string tag, input logic [6:0] expv);
        logic [6:0] obs;
        obs = {s2, s1, s0, valid, busy, wrap, err};
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed sel/v/b/w/e=%b required %b", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [2:0] sel, input logic v, input logic w, input logic e,
                        input string tag);
        exp_q.push_back({sel, v, v, w, e});
        tag_q.push_back(tag);
    endtask

    // One clock: sample 1 time unit after the edge and compare with the queue head.
    task automatic tick();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue required an expectation");
        end else begin
            chk(tag_q.pop_front(), exp_q.pop_front());
        end
    endtask

    task automatic drain();
        while (exp_q.size() != 0) tick();
    endtask

    initial begin
        logic [2:0] sweep[$];

        rst_n = 1'b0; en = 1'b0; mode = 1'b0; start = 1'b0; dir = 1'b0;
        dwell = 8'd0; mask = 8'hFF;
        #2;
        chk("reset", 7'b000_0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // T1: continuous ascending, dwell=2, full mask
        mode = 1'b0; dir = 1'b0; dwell = 8'd2; mask = 8'hFF; en = 1'b1;
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < 3; c++) push(3'(k), 1'b1, 1'b0, 1'b0, "t1_scan");
        push(3'd0, 1'b1, 1'b1, 1'b0, "t1_wrap");
        drain();
        en = 1'b0;
        push(3'd0, 1'b0, 1'b0, 1'b0, "t1_en_off");
        drain();

        // T2: single sweep descending, dwell=0
        mode = 1'b1; dir = 1'b1; dwell = 8'd0; mask = 8'b1010_0101; en = 1'b1; start = 1'b1;
`ifdef DECODER_SCAN_SKIP_MASK_EN
        sweep = '{3'd7, 3'd5, 3'd2, 3'd0};
`else
        sweep = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
`endif
        foreach (sweep[i]) push(sweep[i], 1'b1, 1'b0, 1'b0, "t2_sweep");
        tick();
        start = 1'b0;
        drain();
        push(3'd0, 1'b0, 1'b1, 1'b0, "t2_wrap_idle");
        push(3'd0, 1'b0, 1'b0, 1'b0, "t2_idle_hold");
        drain();

`ifdef DECODER_SCAN_SKIP_MASK_EN
        // T3: single enabled slot wraps onto itself, then an empty mask aborts with err
        mode = 1'b0; dir = 1'b0; dwell = 8'd1; mask = 8'b0001_0000;
        push(3'd4, 1'b1, 1'b0, 1'b0, "t3_entry");
        push(3'd4, 1'b1, 1'b0, 1'b0, "t3_dwell");
        push(3'd4, 1'b1, 1'b1, 1'b0, "t3_wrap1");
        push(3'd4, 1'b1, 1'b0, 1'b0, "t3_dwell");
        push(3'd4, 1'b1, 1'b1, 1'b0, "t3_wrap2");
        drain();
        mask = 8'h00;
        push(3'd4, 1'b1, 1'b0, 1'b0, "t3_cnt0");
        push(3'd4, 1'b0, 1'b0, 1'b1, "t3_err_adv");
        push(3'd4, 1'b0, 1'b0, 1'b1, "t3_err_rep1");
        push(3'd4, 1'b0, 1'b0, 1'b1, "t3_err_rep2");
        drain();
        en = 1'b0;
        push(3'd4, 1'b0, 1'b0, 1'b0, "t3_en_off");
        drain();
        mask = 8'hFF;
`else
        // T3: mask is ignored, so an all-zero mask still gives a full scan without err
        mode = 1'b0; dir = 1'b0; dwell = 8'd0; mask = 8'h00;
        for (int k = 0; k < 8; k++) push(3'(k), 1'b1, 1'b0, 1'b0, "t3_full_scan");
        push(3'd0, 1'b1, 1'b1, 1'b0, "t3_wrap");
        drain();
        en = 1'b0;
        push(3'd0, 1'b0, 1'b0, 1'b0, "t3_en_off");
        drain();
        mask = 8'hFF;
`endif

        // T4: en drops on the cycle slot 7 reaches count 0 -> idle, no wrap
        mode = 1'b0; dir = 1'b0; dwell = 8'd1; en = 1'b1;
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < 2; c++) push(3'(k), 1'b1, 1'b0, 1'b0, "t4_scan");
        drain();
        en = 1'b0;
        push(3'd7, 1'b0, 1'b0, 1'b0, "t4_en_drop");
        drain();

        // T5: asynchronous reset mid-dwell at slot 3, then restart from slot 0
        dwell = 8'd3; en = 1'b1;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++) push(3'(k), 1'b1, 1'b0, 1'b0, "t5_scan");
        push(3'd3, 1'b1, 1'b0, 1'b0, "t5_slot3");
        push(3'd3, 1'b1, 1'b0, 1'b0, "t5_slot3");
        drain();
        rst_n = 1'b0;
        #1;
        chk("t5_async_reset", 7'b000_0000);
        #1;
        rst_n = 1'b1;
        push(3'd0, 1'b1, 1'b0, 1'b0, "t5_restart");
        push(3'd0, 1'b1, 1'b0, 1'b0, "t5_restart_dwell");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
